snd_write_sched: RTL and testbench
==================================

SND_WRITE_SCHED -- requirements
Module: snd_write_sched

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- CLK  in  1  system clock; the same clock that drives the sound core.
- RST  in  1  reset, asynchronous, active-high.
- REQ0_VALID  in  1  requester 0 (host) has a write pending.
- REQ0_CHAN  in  2  target: 0=tone A, 1=tone B, 2=triangle, 3=mixer enable.
- REQ0_DATA  in  12  12-bit period; for CHAN=3 only bits [2:0] are used.
- REQ0_READY  out  1  requester 0 transfer accepted this cycle.
- REQ1_VALID / REQ1_CHAN / REQ1_DATA / REQ1_READY  same widths and meanings for requester 1 (sequencer).
- A0  out  1  bus phase: 0=address nibble, 1=data nibble.
- WR  out  1  bus write strobe, one CLK wide.
- D  out  4  bus nibble.
- BUSY  out  1  a transaction is in progress.
- DONE  out  1  one-cycle pulse on the last data write of a transaction.

Function
REQ-002 A transfer SHALL occur when REQn_VALID and REQn_READY are both 1 on a CLK rising edge.
REQ-003 The payload SHALL be captured into internal registers on acceptance, so that REQn_DATA and REQn_CHAN may change afterwards.
REQ-004 REQn_READY SHALL be asserted only in state IDLE, and only for the granted requester.
REQ-005 At most one REQn_READY SHALL be high in any cycle.
REQ-006 REQn_READY SHALL be combinational from the state, VALID inputs and LAST_GRANT.
REQ-007 Arbitration SHALL work as follows:
- Only one requester valid: that requester is granted.
- Both valid: the requester other than LAST_GRANT is granted.
- LAST_GRANT updates on each transfer.
REQ-008 The FSM states SHALL be IDLE, ADDR, DATA.
- IDLE -> ADDR on a transfer.
- ADDR -> DATA every time.
- DATA -> ADDR if nibbles remain, else DATA -> IDLE.
REQ-009 The nibble count SHALL be 3 for CHAN 0..2, ordered low, high, top nibble of DATA. It SHALL be 1 for CHAN 3.
REQ-010 The address nibble SHALL be computed as follows:
- CHAN 0: 1, 2, 3.
- CHAN 1: 4, 5, 6.
- CHAN 2: 7, 8, 9.
- CHAN 3: 15.
REQ-011 In ADDR the outputs SHALL be WR=1, A0=0, D=address nibble.
REQ-012 In DATA the outputs SHALL be WR=1, A0=1, D=data nibble. For CHAN 3, D = {0, DATA[2:0]}.
REQ-013 A0, WR and D SHALL be registered outputs. In IDLE they SHALL be WR=0, A0=0, D=0.
REQ-014 The first WR SHALL occur in the cycle after acceptance. A 12-bit write SHALL occupy 6 WR cycles and a mixer write 2 WR cycles, without GAP.
REQ-015 BUSY SHALL be 1 in every non-IDLE state.
REQ-016 DONE SHALL be high in the cycle of the final DATA WR.
REQ-017 From DONE the FSM SHALL return to IDLE. The earliest next acceptance SHALL be the cycle after DONE.
REQ-018 When both requesters are continuously valid, grants SHALL strictly alternate 0,1,0,1.
REQ-019 A VALID that drops before acceptance SHALL be ignored with no bus activity.
REQ-020 VALID asserted while BUSY SHALL be held off (READY=0) and granted on return to IDLE.

Reset
REQ-021 RST=1 SHALL immediately, without waiting for a clock edge, force:
- FSM to IDLE.
- WR=0, A0=0, D=0.
- BUSY=0, DONE=0.
- LAST_GRANT=1, so requester 0 wins the first tie.
- Nibble counter to 0.
REQ-022 RST asserted mid-transaction SHALL abandon the transaction. No further WR SHALL occur for it, and no DONE SHALL be issued.
REQ-023 Both READY outputs SHALL be 0 while RST=1.

Configuration
REQ-024 Macro SND_WRITE_SCHED_GAP_EN SHALL select bus recovery timing.
- When defined: a state GAP with WR=0, A0 and D held, SHALL follow every ADDR and every DATA cycle, including the last. A 12-bit write is 12 cycles, a mixer write 4 cycles. DONE pulses in the final DATA cycle, and IDLE is re-entered after the trailing GAP.
- When undefined: no GAP state exists and timing is per REQ-014.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response, no GAP unless stated):
- Reset, then REQ0 CHAN=0 DATA=0xABC -> WR bursts (A0,D) = (0,1)(1,C)(0,2)(1,B)(0,3)(1,A); DONE on the 6th; BUSY high for 6 cycles.
- REQ1 CHAN=3 DATA=0x005 -> (0,F)(1,5); DONE on the 2nd.
- Both valid from reset, REQ0 CHAN=2 DATA=0x123, REQ1 CHAN=1 DATA=0x456 -> REQ0 served first with addresses 7,8,9; then REQ1 with addresses 4,5,6; grants alternate over 4 further back-to-back pairs.
- RST pulsed after the 3rd WR of a CHAN=0 write -> outputs zero immediately; no DONE; next request starts at its own first address.
- GAP_EN defined, CHAN=1 DATA=0x0F0 -> 12 cycles, WR pattern 1,0 repeated; nibbles 0,F,0 at addresses 4,5,6.
- REQ0_VALID pulsed while BUSY and held -> READY stays 0 until IDLE, then transfers with no WR lost from the ongoing transaction.

Source files
------------

// File: rtl/snd_write_sched.sv
// Write scheduler for the sound core: two requesters share a nibble-wide
// address/data bus. Define SND_WRITE_SCHED_GAP_EN to add a recovery cycle after every bus write.
module snd_write_sched (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  input  logic [1:0]  REQ0_CHAN,
  input  logic [11:0] REQ0_DATA,
  output logic        REQ0_READY,
  input  logic        REQ1_VALID,
  input  logic [1:0]  REQ1_CHAN,
  input  logic [11:0] REQ1_DATA,
  output logic        REQ1_READY,
  output logic        A0,
  output logic        WR,
  output logic [3:0]  D,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
`ifdef SND_WRITE_SCHED_GAP_EN
    , GAP = 2'd3
`endif
  } state_t;

  state_t      state_q;
  logic [1:0]  chan_q;
  logic [11:0] data_q;
  logic [1:0]  nib_q;
  logic        last_grant_q;
  logic        wr_q, a0_q, done_q;
  logic [3:0]  d_q;

  logic        grant0, grant1, take, last_nib;
  logic [1:0]  sel_chan, nib_inc;
  logic [11:0] sel_data;

  function automatic logic [3:0] addr_nibble(input logic [1:0] chan, input logic [1:0] nib);
    if (chan == 2'd3) return 4'hF;
    return {2'b00, chan} * 4'd3 + {2'b00, nib} + 4'd1;
  endfunction

  function automatic logic [3:0] data_nibble(input logic [1:0] chan, input logic [11:0] data,
                                             input logic [1:0] nib);
    if (chan == 2'd3) return {1'b0, data[2:0]};
    case (nib)
      2'd0:    return data[3:0];
      2'd1:    return data[7:4];
      default: return data[11:8];
    endcase
  endfunction

  // On a tie the requester that did not win last time gets the bus.
  assign grant0 = REQ0_VALID & (~REQ1_VALID | last_grant_q);
  assign grant1 = REQ1_VALID & (~REQ0_VALID | ~last_grant_q);

  // NOTE: the async reset already forces IDLE, but READY must also stay low
  // during the reset pulse itself, so RST gates it explicitly.
  assign REQ0_READY = (state_q == IDLE) & ~RST & grant0;
  assign REQ1_READY = (state_q == IDLE) & ~RST & grant1;
  assign take       = REQ0_READY | REQ1_READY;

  assign sel_chan = grant0 ? REQ0_CHAN : REQ1_CHAN;
  assign sel_data = grant0 ? REQ0_DATA : REQ1_DATA;
  assign last_nib = (chan_q == 2'd3) | (nib_q == 2'd2);
  assign nib_inc  = nib_q + 2'd1;

  // NOTE: all state and output registers use non-blocking assignments so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      chan_q       <= 2'd0;
      data_q       <= 12'd0;
      nib_q        <= 2'd0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      a0_q         <= 1'b0;
      d_q          <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take) begin
            chan_q       <= sel_chan;
            data_q       <= sel_data;
            nib_q        <= 2'd0;
            last_grant_q <= grant1;
            state_q      <= ADDR;
            wr_q         <= 1'b1;
            a0_q         <= 1'b0;
            d_q          <= addr_nibble(sel_chan, 2'd0);
          end
        end
`ifdef SND_WRITE_SCHED_GAP_EN
        ADDR, DATA: begin
          state_q <= GAP;
          wr_q    <= 1'b0;
        end
        GAP: begin
          if (!a0_q) begin
            state_q <= DATA;
            wr_q    <= 1'b1;
            a0_q    <= 1'b1;
            d_q     <= data_nibble(chan_q, data_q, nib_q);
            done_q  <= last_nib;
          end else if (last_nib) begin
            state_q <= IDLE;
            a0_q    <= 1'b0;
            d_q     <= 4'd0;
          end else begin
            state_q <= ADDR;
            nib_q   <= nib_inc;
            wr_q    <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= addr_nibble(chan_q, nib_inc);
          end
        end
`else
        ADDR: begin
          state_q <= DATA;
          wr_q    <= 1'b1;
          a0_q    <= 1'b1;
          d_q     <= data_nibble(chan_q, data_q, nib_q);
          done_q  <= last_nib;
        end
        DATA: begin
          if (last_nib) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            a0_q    <= 1'b0;
            d_q     <= 4'd0;
          end else begin
            state_q <= ADDR;
            nib_q   <= nib_inc;
            wr_q    <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= addr_nibble(chan_q, nib_inc);
          end
        end
        default: state_q <= IDLE;
`endif
      endcase
    end
  end

  assign WR   = wr_q;
  assign A0   = a0_q;
  assign D    = d_q;
  assign DONE = done_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_snd_write_sched.sv
// Directed bench for snd_write_sched; expected bus nibble sequences are written out by hand.
// Also covers the recovery-cycle build when SND_WRITE_SCHED_GAP_EN is defined.
`timescale 1ns/1ps
module tb_snd_write_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ1_VALID;
  logic [1:0]  REQ0_CHAN, REQ1_CHAN;
  logic [11:0] REQ0_DATA, REQ1_DATA;
  logic        REQ0_READY, REQ1_READY;
  logic        A0, WR, BUSY, DONE;
  logic [3:0]  D;

  int total = 0;
  int bad   = 0;

  snd_write_sched dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_CHAN(REQ0_CHAN), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_CHAN(REQ1_CHAN), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .A0(A0), .WR(WR), .D(D), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr"},   32'(WR),   0);
    check({tag, "_a0"},   32'(A0),   0);
    check({tag, "_d"},    32'(D),    0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
  endtask

  // Called at the falling edge of the first WR cycle; seq holds the bus
  // nibbles in order, most significant nibble first. Returns at the IDLE cycle.
  task automatic expect_burst(input string tag, input int n, input logic [23:0] seq);
    logic [3:0] nib;
    for (int i = 0; i < n; i++) begin
      nib = seq[23-4*i -: 4];
      check($sformatf("%s_wr%0d", tag, i),   32'(WR),   1);
      check($sformatf("%s_a0%0d", tag, i),   32'(A0),   32'(i % 2));
      check($sformatf("%s_d%0d", tag, i),    32'(D),    32'(nib));
      check($sformatf("%s_busy%0d", tag, i), 32'(BUSY), 1);
      check($sformatf("%s_done%0d", tag, i), 32'(DONE), 32'(i == n - 1));
      check($sformatf("%s_rdy%0d", tag, i),  32'({REQ0_READY, REQ1_READY}), 0);
      @(negedge CLK);
`ifdef SND_WRITE_SCHED_GAP_EN
      check($sformatf("%s_gwr%0d", tag, i),   32'(WR),   0);
      check($sformatf("%s_ga0%0d", tag, i),   32'(A0),   32'(i % 2));
      check($sformatf("%s_gd%0d", tag, i),    32'(D),    32'(nib));
      check($sformatf("%s_gbusy%0d", tag, i), 32'(BUSY), 1);
      check($sformatf("%s_gdone%0d", tag, i), 32'(DONE), 0);
      @(negedge CLK);
`endif
    end
    check({tag, "_end_busy"}, 32'(BUSY), 0);
    check({tag, "_end_wr"},   32'(WR),   0);
    check({tag, "_end_d"},    32'(D),    0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrs;
    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ0_CHAN = 2'd0; REQ0_DATA = 12'h000;
    REQ1_VALID = 1'b0; REQ1_CHAN = 2'd0; REQ1_DATA = 12'h000;
    @(negedge CLK);
    check_quiet("reset");
    check("reset_ready0", 32'(REQ0_READY), 0);
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Valid pulse that falls before any rising edge must not start a write.
    REQ0_VALID = 1'b1;
    #2 REQ0_VALID = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_quiet("pulse");
    end

    // Tone A, data changed right after acceptance.
    REQ0_VALID = 1'b1; REQ0_CHAN = 2'd0; REQ0_DATA = 12'hABC;
    #1 check("toneA_ready0", 32'(REQ0_READY), 1);
    @(negedge CLK);
    REQ0_VALID = 1'b0; REQ0_CHAN = 2'd3; REQ0_DATA = 12'h000;
    expect_burst("toneA", 6, 24'h1C2B3A);

    // Mixer write from requester 1.
    REQ1_VALID = 1'b1; REQ1_CHAN = 2'd3; REQ1_DATA = 12'h005;
    #1 check("mix_ready", 32'({REQ0_READY, REQ1_READY}), 32'b01);
    @(negedge CLK);
    REQ1_VALID = 1'b0;
    expect_burst("mix", 2, 24'hF50000);

    // Both continuously valid from reset: strict alternation, requester 0 first.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    REQ0_VALID = 1'b1; REQ0_CHAN = 2'd2; REQ0_DATA = 12'h123;
    REQ1_VALID = 1'b1; REQ1_CHAN = 2'd1; REQ1_DATA = 12'h456;
    #1;
    for (int p = 0; p < 5; p++) begin
      check($sformatf("alt_grant0_%0d", p), 32'({REQ0_READY, REQ1_READY}), 32'b10);
      @(negedge CLK);
      expect_burst("alt_r0", 6, 24'h738291);
      check($sformatf("alt_grant1_%0d", p), 32'({REQ0_READY, REQ1_READY}), 32'b01);
      @(negedge CLK);
      expect_burst("alt_r1", 6, 24'h465564);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

    // Reset after the third WR abandons the transaction.
    REQ0_VALID = 1'b1; REQ0_CHAN = 2'd0; REQ0_DATA = 12'hABC;
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    wrs = 0;
    for (int k = 0; k < 12 && wrs < 3; k++) begin
      if (WR) wrs++;
      if (wrs < 3) @(negedge CLK);
    end
    check("abort_wr_count", 32'(wrs), 3);
    RST = 1'b1;
    #1 check_quiet("abort_now");
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_quiet("abort_after");
    end
    REQ1_VALID = 1'b1; REQ1_CHAN = 2'd1; REQ1_DATA = 12'h456;
    @(negedge CLK);
    REQ1_VALID = 1'b0;
    expect_burst("restart", 6, 24'h465564);

    // Tone B 0x0F0 (the recovery-cycle pattern when that build is selected).
    REQ1_VALID = 1'b1; REQ1_CHAN = 2'd1; REQ1_DATA = 12'h0F0;
    @(negedge CLK);
    REQ1_VALID = 1'b0;
    expect_burst("gap", 6, 24'h405F60);

    // Request raised while busy is held off and served when idle again.
    REQ1_VALID = 1'b1; REQ1_CHAN = 2'd3; REQ1_DATA = 12'h007;
    @(negedge CLK);
    REQ1_VALID = 1'b0;
    REQ0_VALID = 1'b1; REQ0_CHAN = 2'd0; REQ0_DATA = 12'h321;
    #1 expect_burst("held_mix", 2, 24'hF70000);
    check("held_ready0", 32'(REQ0_READY), 1);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    expect_burst("held_tone", 6, 24'h112233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
